mc_control_fsm: RTL and testbench

- Main control unit for the multicycle processor datapath.
- Sequences each instruction through fetch, decode, execute, memory and writeback states, and drives every datapath select and enable.
- Derives PC-source select (PCS) internally from destination register, register-write and branch, using the same rule as pc_decoder.
- Gates all architectural writes with the externally supplied condition result.

---
 rtl/mc_control_fsm_if.sv | 45 ++++
 rtl/mc_control_fsm.sv | 169 ++++++++++++++++
 tb/tb_mc_control_fsm.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/mc_control_fsm_if.sv
`default_nettype none
// ============================================================================
//  Module      : mc_control_fsm_if
//  Description : Instruction fields, memory handshake and datapath control
//                bundle between the multicycle control FSM and the datapath.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mc_control_fsm_if;
   // Instruction fields and status coming from the datapath
   logic [1:0] op;
   logic [5:0] funct;
   logic [3:0] rd;
   logic       cond_ex;
   logic       mem_ready;

   // Controls going to the datapath
   logic       pc_write;
   logic       ir_write;
   logic       mem_write;
   logic       reg_write;
   logic       adr_src;
   logic       alu_src_a;
   logic [1:0] alu_src_b;
   logic [1:0] alu_control;
   logic [1:0] result_src;
   logic [1:0] imm_src;
   logic [1:0] reg_src;
   logic       pcs;
   logic [3:0] state;

   // Datapath side
   modport master (
      output op, funct, rd, cond_ex, mem_ready,
      input  pc_write, ir_write, mem_write, reg_write, adr_src, alu_src_a,
             alu_src_b, alu_control, result_src, imm_src, reg_src, pcs, state
   );

   // Control unit side
   modport slave (
      input  op, funct, rd, cond_ex, mem_ready,
      output pc_write, ir_write, mem_write, reg_write, adr_src, alu_src_a,
             alu_src_b, alu_control, result_src, imm_src, reg_src, pcs, state
   );
endinterface
`default_nettype wire

// File: rtl/mc_control_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : mc_control_fsm
//  Description : Main control FSM of the multicycle processor. Steps each
//                instruction through fetch/decode/execute/memory/writeback,
//                drives datapath selects, derives PCS and gates every
//                architectural write with the condition result.
//  Revision    : 1.0 - initial release
// ============================================================================
module mc_control_fsm #(
   parameter logic [3:0] PC_REG   = 4'd15,
   parameter bit         WAIT_MEM = 1'b1
) (
   input  wire logic         clk,
   input  wire logic         reset,
   mc_control_fsm_if.slave   bus
);

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_EXECI    = 4'd7,
      S_ALUWB    = 4'd8,
      S_BRANCH   = 4'd9
   } state_t;

   // State-decoded controls; registered together with the state so they
   // come straight from flops rather than a decoder behind the state reg.
   typedef struct packed {
      logic       adr_src;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] result_src;
      logic       alu_op;
      logic       regw;
      logic       memw;
      logic       branch;
      logic       fetch;
   } ctrl_t;

   function automatic ctrl_t decode_ctrl(input state_t s);
      ctrl_t c;
      c = '0;
      case (s)
         S_FETCH: begin
            c.alu_src_a  = 1'b1;
            c.alu_src_b  = 2'b10;
            c.result_src = 2'b10;
            c.fetch      = 1'b1;
         end
         S_DECODE: begin
            c.alu_src_a  = 1'b1;
            c.alu_src_b  = 2'b10;
            c.result_src = 2'b10;
         end
         S_MEMADR:   c.alu_src_b = 2'b01;
         S_MEMREAD:  c.adr_src   = 1'b1;
         S_MEMWB: begin
            c.result_src = 2'b01;
            c.regw       = 1'b1;
         end
         S_MEMWRITE: begin
            c.adr_src = 1'b1;
            c.memw    = 1'b1;
         end
         S_EXECR: begin
            c.alu_src_b = 2'b00;
            c.alu_op    = 1'b1;
         end
         S_EXECI: begin
            c.alu_src_b = 2'b01;
            c.alu_op    = 1'b1;
         end
         S_ALUWB:    c.regw = 1'b1;
         S_BRANCH: begin
            c.alu_src_b  = 2'b01;
            c.result_src = 2'b10;
            c.branch     = 1'b1;
         end
         default:    c = '0;
      endcase
      return c;
   endfunction

   state_t     r_state;
   ctrl_t      r_ctrl;
   state_t     w_next;
   logic       w_mem_ok;
   logic       w_next_pc;
   logic       w_pcs;
   logic [1:0] w_alu_control;

   // With WAIT_MEM cleared the memory is assumed to always answer in one cycle
   assign w_mem_ok = WAIT_MEM ? bus.mem_ready : 1'b1;

   // Next-state selection
   always_comb begin
      w_next = S_FETCH;
      case (r_state)
         S_FETCH:    w_next = w_mem_ok ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (bus.op)
               2'b00:   w_next = bus.funct[5] ? S_EXECI : S_EXECR;
               2'b01:   w_next = S_MEMADR;
               2'b10:   w_next = S_BRANCH;
               default: w_next = S_FETCH;
            endcase
         end
         S_MEMADR:   w_next = bus.funct[0] ? S_MEMREAD : S_MEMWRITE;
         S_MEMREAD:  w_next = w_mem_ok ? S_MEMWB : S_MEMREAD;
         S_MEMWRITE: w_next = w_mem_ok ? S_FETCH : S_MEMWRITE;
         S_EXECR:    w_next = S_ALUWB;
         S_EXECI:    w_next = S_ALUWB;
         default:    w_next = S_FETCH;
      endcase
   end

   // State register plus registered decode of the state being entered
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_FETCH;
         r_ctrl  <= decode_ctrl(S_FETCH);
      end else begin
         r_state <= w_next;
         r_ctrl  <= decode_ctrl(w_next);
      end
   end

   // ALU function select from the instruction cmd field
   always_comb begin
      w_alu_control = 2'b00;
      if (r_ctrl.alu_op) begin
         case (bus.funct[4:1])
            4'b0100: w_alu_control = 2'b00;
            4'b0010: w_alu_control = 2'b01;
            4'b0000: w_alu_control = 2'b10;
            4'b1100: w_alu_control = 2'b11;
            default: w_alu_control = 2'b00;
         endcase
      end
   end

   // PC increment happens only on the fetch cycle that actually completes
   assign w_next_pc = r_ctrl.fetch & w_mem_ok;
   assign w_pcs     = ((bus.rd == PC_REG) & r_ctrl.regw) | r_ctrl.branch;

   // Architectural writes are squashed by a failed condition or by reset
   assign bus.pc_write    = ~reset & (w_next_pc | (w_pcs & bus.cond_ex));
   assign bus.ir_write    = ~reset & w_next_pc;
   assign bus.reg_write   = ~reset & r_ctrl.regw & bus.cond_ex;
   assign bus.mem_write   = ~reset & r_ctrl.memw & bus.cond_ex;

   assign bus.pcs         = w_pcs;
   assign bus.adr_src     = r_ctrl.adr_src;
   assign bus.alu_src_a   = r_ctrl.alu_src_a;
   assign bus.alu_src_b   = r_ctrl.alu_src_b;
   assign bus.result_src  = r_ctrl.result_src;
   assign bus.alu_control = w_alu_control;
   assign bus.imm_src     = bus.op;
   assign bus.reg_src     = {(bus.op == 2'b01), (bus.op == 2'b10)};
   assign bus.state       = r_state;

endmodule
`default_nettype wire

// File: tb/tb_mc_control_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mc_control_fsm
//  Description : Self-checking bench for mc_control_fsm. A plan-queue model
//                predicts the state sequence of each instruction and the
//                per-state control table; directed scenarios add literal
//                expectations, then a randomized run follows.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mc_control_fsm;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   mc_control_fsm_if bus();

   mc_control_fsm #(
      .PC_REG   (4'd15),
      .WAIT_MEM (1'b1)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int errors = 0;
   int checks = 0;

   // Model: current state number and the remaining states of the instruction
   int m_state = 0;
   int m_next  = 0;
   int m_plan[$];

   task automatic cmp(input string name, input logic [3:0] act, input logic [3:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Compare every DUT output with the model, then advance the model's plan
   task automatic model_check();
      logic       ok, regw, memw, br, alu_op, adr, srca, next_pc, pcs;
      logic [1:0] srcb, rsrc, aluc;
      ok      = bus.mem_ready;
      regw    = (m_state == 4) || (m_state == 8);
      memw    = (m_state == 5);
      br      = (m_state == 9);
      alu_op  = (m_state == 6) || (m_state == 7);
      adr     = (m_state == 3) || (m_state == 5);
      srca    = (m_state == 0) || (m_state == 1);
      srcb    = (m_state <= 1) ? 2'b10 :
                ((m_state == 2) || (m_state == 7) || (m_state == 9)) ? 2'b01 : 2'b00;
      rsrc    = ((m_state <= 1) || (m_state == 9)) ? 2'b10 :
                (m_state == 4) ? 2'b01 : 2'b00;
      aluc    = 2'b00;
      if (alu_op) begin
         if      (bus.funct[4:1] == 4'b0010) aluc = 2'b01;
         else if (bus.funct[4:1] == 4'b0000) aluc = 2'b10;
         else if (bus.funct[4:1] == 4'b1100) aluc = 2'b11;
      end
      next_pc = (m_state == 0) && ok;
      pcs     = ((bus.rd == 4'd15) && regw) || br;

      cmp("state",       bus.state,       4'(m_state));
      cmp("pc_write",    {3'b0, bus.pc_write},  {3'b0, !reset && (next_pc || (pcs && bus.cond_ex))});
      cmp("ir_write",    {3'b0, bus.ir_write},  {3'b0, !reset && next_pc});
      cmp("reg_write",   {3'b0, bus.reg_write}, {3'b0, !reset && regw && bus.cond_ex});
      cmp("mem_write",   {3'b0, bus.mem_write}, {3'b0, !reset && memw && bus.cond_ex});
      cmp("adr_src",     {3'b0, bus.adr_src},   {3'b0, adr});
      cmp("alu_src_a",   {3'b0, bus.alu_src_a}, {3'b0, srca});
      cmp("alu_src_b",   {2'b0, bus.alu_src_b}, {2'b0, srcb});
      cmp("alu_control", {2'b0, bus.alu_control}, {2'b0, aluc});
      cmp("result_src",  {2'b0, bus.result_src},  {2'b0, rsrc});
      cmp("imm_src",     {2'b0, bus.imm_src},     {2'b0, bus.op});
      cmp("reg_src",     {2'b0, bus.reg_src},
          {2'b0, (bus.op == 2'b01), (bus.op == 2'b10)});
      cmp("pcs",         {3'b0, bus.pcs},         {3'b0, pcs});

      if (reset) begin
         m_next = 0;
         m_plan.delete();
      end else if (m_state == 0) begin
         m_next = ok ? 1 : 0;
      end else if (m_state == 1) begin
         m_plan.delete();
         case (bus.op)
            2'b00: m_plan = bus.funct[5] ? {7, 8} : {6, 8};
            2'b01: m_plan = bus.funct[0] ? {2, 3, 4} : {2, 5};
            2'b10: m_plan = {9};
            default: m_plan.delete();
         endcase
         m_next = (m_plan.size() == 0) ? 0 : m_plan.pop_front();
      end else if ((m_state == 3 || m_state == 5) && !ok) begin
         m_next = m_state;
      end else begin
         m_next = (m_plan.size() == 0) ? 0 : m_plan.pop_front();
      end
   endtask

   // One clock: advance model, drive inputs just after the edge, check mid-cycle
   task automatic cycle(input logic [1:0] op, input logic [5:0] f, input logic [3:0] rd,
                        input logic ce, input logic mr, input logic rst);
      @(posedge clk);
      m_state = m_next;
      #1;
      bus.op        = op;
      bus.funct     = f;
      bus.rd        = rd;
      bus.cond_ex   = ce;
      bus.mem_ready = mr;
      reset         = rst;
      @(negedge clk);
      model_check();
   endtask

   logic [1:0] r_op;
   logic [5:0] r_f;
   logic [3:0] r_rd;

   initial begin
      reset         = 1'b1;
      bus.op        = 2'b00;
      bus.funct     = 6'b0;
      bus.rd        = 4'd0;
      bus.cond_ex   = 1'b0;
      bus.mem_ready = 1'b0;

      // Reset held two cycles
      cycle(2'b00, 6'b101000, 4'd2, 1'b1, 1'b1, 1'b1);
      cycle(2'b00, 6'b101000, 4'd2, 1'b1, 1'b1, 1'b1);
      cmp("lit_reset_state", bus.state, 4'd0);
      cmp("lit_reset_pcw", {3'b0, bus.pc_write}, 4'd0);

      // ADD immediate, rd=2: 0,1,7,8,0
      cycle(2'b00, 6'b101000, 4'd2, 1'b1, 1'b1, 1'b0);
      cmp("lit_add_fetch_pcw", {3'b0, bus.pc_write}, 4'd1);
      cmp("lit_add_fetch_irw", {3'b0, bus.ir_write}, 4'd1);
      cycle(2'b00, 6'b101000, 4'd2, 1'b1, 1'b1, 1'b0);
      cmp("lit_add_s1", bus.state, 4'd1);
      cycle(2'b00, 6'b101000, 4'd2, 1'b1, 1'b1, 1'b0);
      cmp("lit_add_s7", bus.state, 4'd7);
      cmp("lit_add_aluc", {2'b0, bus.alu_control}, 4'd0);
      cycle(2'b00, 6'b101000, 4'd2, 1'b1, 1'b1, 1'b0);
      cmp("lit_add_s8", bus.state, 4'd8);
      cmp("lit_add_regw", {3'b0, bus.reg_write}, 4'd1);
      cmp("lit_add_wb_pcw", {3'b0, bus.pc_write}, 4'd0);

      // LDR with two wait cycles in MEMREAD
      cycle(2'b01, 6'b011001, 4'd3, 1'b1, 1'b1, 1'b0);
      cmp("lit_ldr_s0", bus.state, 4'd0);
      cycle(2'b01, 6'b011001, 4'd3, 1'b1, 1'b1, 1'b0);
      cycle(2'b01, 6'b011001, 4'd3, 1'b1, 1'b1, 1'b0);
      cmp("lit_ldr_s2", bus.state, 4'd2);
      for (int i = 0; i < 3; i++) begin
         cycle(2'b01, 6'b011001, 4'd3, 1'b1, (i == 2), 1'b0);
         cmp("lit_ldr_s3", bus.state, 4'd3);
         cmp("lit_ldr_adr", {3'b0, bus.adr_src}, 4'd1);
      end
      cycle(2'b01, 6'b011001, 4'd3, 1'b1, 1'b1, 1'b0);
      cmp("lit_ldr_s4", bus.state, 4'd4);
      cmp("lit_ldr_rsrc", {2'b0, bus.result_src}, 4'd1);
      cmp("lit_ldr_regw", {3'b0, bus.reg_write}, 4'd1);

      // STR with failed condition
      cycle(2'b01, 6'b011000, 4'd3, 1'b0, 1'b1, 1'b0);
      cycle(2'b01, 6'b011000, 4'd3, 1'b0, 1'b1, 1'b0);
      cycle(2'b01, 6'b011000, 4'd3, 1'b0, 1'b1, 1'b0);
      cycle(2'b01, 6'b011000, 4'd3, 1'b0, 1'b0, 1'b0);
      cmp("lit_str_s5", bus.state, 4'd5);
      cmp("lit_str_memw", {3'b0, bus.mem_write}, 4'd0);
      cycle(2'b01, 6'b011000, 4'd3, 1'b0, 1'b1, 1'b0);
      cmp("lit_str_memw2", {3'b0, bus.mem_write}, 4'd0);

      // Branch taken, then not taken
      for (int t = 0; t < 2; t++) begin
         cycle(2'b10, 6'b000000, 4'd0, (t == 0), 1'b1, 1'b0);
         cmp("lit_br_s0", bus.state, 4'd0);
         cycle(2'b10, 6'b000000, 4'd0, (t == 0), 1'b1, 1'b0);
         cycle(2'b10, 6'b000000, 4'd0, (t == 0), 1'b1, 1'b0);
         cmp("lit_br_s9", bus.state, 4'd9);
         cmp("lit_br_pcs", {3'b0, bus.pcs}, 4'd1);
         cmp("lit_br_pcw", {3'b0, bus.pc_write}, (t == 0) ? 4'd1 : 4'd0);
      end

      // SUB register form writing the PC
      cycle(2'b00, 6'b000100, 4'd15, 1'b1, 1'b1, 1'b0);
      cycle(2'b00, 6'b000100, 4'd15, 1'b1, 1'b1, 1'b0);
      cycle(2'b00, 6'b000100, 4'd15, 1'b1, 1'b1, 1'b0);
      cmp("lit_sub_s6", bus.state, 4'd6);
      cmp("lit_sub_aluc", {2'b0, bus.alu_control}, 4'd1);
      cycle(2'b00, 6'b000100, 4'd15, 1'b1, 1'b1, 1'b0);
      cmp("lit_sub_pcs", {3'b0, bus.pcs}, 4'd1);
      cmp("lit_sub_pcw", {3'b0, bus.pc_write}, 4'd1);
      cmp("lit_sub_regw", {3'b0, bus.reg_write}, 4'd1);

      // Reset while stalled in MEMWRITE, then an undefined op
      cycle(2'b01, 6'b011000, 4'd4, 1'b1, 1'b1, 1'b0);
      cycle(2'b01, 6'b011000, 4'd4, 1'b1, 1'b1, 1'b0);
      cycle(2'b01, 6'b011000, 4'd4, 1'b1, 1'b1, 1'b0);
      cycle(2'b01, 6'b011000, 4'd4, 1'b1, 1'b0, 1'b1);
      cmp("lit_rst_s5", bus.state, 4'd5);
      cmp("lit_rst_memw", {3'b0, bus.mem_write}, 4'd0);
      cycle(2'b11, 6'b000000, 4'd1, 1'b1, 1'b1, 1'b0);
      cmp("lit_rst_s0", bus.state, 4'd0);
      cycle(2'b11, 6'b000000, 4'd1, 1'b1, 1'b1, 1'b0);
      cmp("lit_nop_s1", bus.state, 4'd1);
      cmp("lit_nop_writes", {bus.pc_write, bus.ir_write, bus.reg_write, bus.mem_write}, 4'd0);
      cycle(2'b11, 6'b000000, 4'd1, 1'b1, 1'b1, 1'b0);
      cmp("lit_nop_back", bus.state, 4'd0);

      // Randomized instruction stream; fields change only when fetching
      r_op = 2'b00;
      r_f  = 6'b0;
      r_rd = 4'd0;
      for (int n = 0; n < 3000; n++) begin
         if (m_next == 0) begin
            r_op = 2'($urandom_range(0, 3));
            r_f  = 6'($urandom);
            r_rd = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom);
         end
         cycle(r_op, r_f, r_rd, 1'($urandom), ($urandom_range(0, 3) != 0),
               ($urandom_range(0, 63) == 0));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
